// File: rtl/sar_cs_pkg.sv
// Shared types and helpers for the parametrised coarse-fine SAR controller.
package sar_cs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_COARSE,
    ST_XFER,
    ST_FINE,
    ST_DONE
  } sar_state_e;

  // Clock cycles from the edge that samples cnvst to the edge raising eoc.
  function automatic int unsigned conv_latency(input int unsigned n,
                                               input int unsigned k,
                                               input int unsigned sample_cycles,
                                               input int unsigned redun);
    return sample_cycles + 2 * k + 1 + 2 * (n - k + redun) + 1;
  endfunction

endpackage

// File: rtl/sar_logic_cs_param_stepper.sv
// One-hot bit pointer walking MSB to LSB with a two-phase (A/B) toggle per bit.
module sar_bit_stepper #(
  parameter int unsigned BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  output logic [BITS-1:0] bit_oh,
  output logic            phase_b,
  output logic            last
);

  logic [BITS-1:0] oh_q, oh_d;
  logic            ph_q, ph_d;

  // Load pointer at MSB on start; otherwise A->B, then B->A of the next bit.
  always_comb begin
    oh_d = oh_q;
    ph_d = ph_q;
    if (start) begin
      oh_d           = '0;
      oh_d[BITS-1]   = 1'b1;
      ph_d           = 1'b0;
    end else if (step) begin
      if (!ph_q) begin
        ph_d = 1'b1;
      end else begin
        ph_d = 1'b0;
        oh_d = oh_q >> 1;
      end
    end
  end

  // Pointer and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oh_q <= '0;
      ph_q <= 1'b0;
    end else begin
      oh_q <= oh_d;
      ph_q <= ph_d;
    end
  end

  assign bit_oh  = oh_q;
  assign phase_b = ph_q;
  assign last    = ph_q & oh_q[0];

endmodule

// File: rtl/sar_logic_cs_param.sv
// Coarse-fine SAR sequencer: sample, coarse search, transfer, fine search, done.
// Every control output is registered from the current state, so it shows up
// one cycle after the state/phase that produced it; comparator decisions are
// latched on the edge that ends the cycle in which its clock is high.
module sar_logic_cs_param
  import sar_cs_pkg::*;
#(
  parameter int unsigned N             = 10,
  parameter int unsigned K             = 7,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned REDUN         = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cnvst,
  input  logic           cont,
  input  logic           cmp_out,
  input  logic           cmp_out_coarse,
  output logic [N-1:0]   sar,
  output logic           eoc,
  output logic           cmp_clk,
  output logic           cmp_clk_coarse,
  output logic           s_clk,
  output logic [2*N-1:0] fine_btm,
  output logic [2*K-1:0] coarse_btm,
  output logic           fine_switch_drain,
  output logic           coarse_switch_drain,
  output logic           s_clk_not,
  output logic [2*N-1:0] fine_btm_not,
  output logic [2*K-1:0] coarse_btm_not,
  output logic           fine_switch_drain_not,
  output logic           coarse_switch_drain_not
);

  localparam int unsigned F   = N - K + REDUN;
  localparam int unsigned SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  sar_state_e     state_q, state_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [N-1:0]   sar_q, sar_d, code_q, code_d;
  logic [N-1:0]   fp_q, fp_d, fn_q, fn_d;
  logic [K-1:0]   cp_q, cp_d, cn_q, cn_d;
  logic           eoc_q, eoc_d, ck_q, ck_d, ckc_q, ckc_d, s_q, s_d;
  logic           fdr_q, fdr_d, cdr_q, cdr_d;

  logic           sample_last;
  logic [K-1:0]   c_oh;
  logic [F-1:0]   f_oh;
  logic           c_ph, c_last, f_ph, f_last;
  logic [N-1:0]   fmask;
  logic           redund_step;

  assign sample_last = (scnt_q == SCW'(SAMPLE_CYCLES - 1));

  sar_bit_stepper #(.BITS(K)) u_coarse_step (
    .clk    (clk),
    .rst_n  (rst),
    .start  (state_q == ST_SAMPLE && sample_last),
    .step   (state_q == ST_COARSE),
    .bit_oh (c_oh),
    .phase_b(c_ph),
    .last   (c_last)
  );

  sar_bit_stepper #(.BITS(F)) u_fine_step (
    .clk    (clk),
    .rst_n  (rst),
    .start  (state_q == ST_XFER),
    .step   (state_q == ST_FINE),
    .bit_oh (f_oh),
    .phase_b(f_ph),
    .last   (f_last)
  );

  // Fine pointer mapped onto code positions; with redundancy its first bit lands on N-K.
  always_comb begin
    fmask          = '0;
    fmask[F-1:0]   = f_oh;
    redund_step    = (REDUN != 0) && fmask[N-K];
  end

  // Next-state sequencing and sample-length counter.
  always_comb begin
    state_d = state_q;
    scnt_d  = '0;
    unique case (state_q)
      ST_IDLE:   if (cnvst) state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        if (sample_last) state_d = ST_COARSE;
        else             scnt_d  = scnt_q + 1'b1;
      end
      ST_COARSE: if (c_last) state_d = ST_XFER;
      ST_XFER:   state_d = ST_FINE;
      ST_FINE:   if (f_last) state_d = ST_DONE;
      ST_DONE:   state_d = cont ? ST_SAMPLE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output, bottom-plate and working-code updates for the current state.
  always_comb begin
    sar_d  = sar_q;
    code_d = code_q;
    fp_d   = fp_q;
    fn_d   = fn_q;
    cp_d   = cp_q;
    cn_d   = cn_q;
    eoc_d  = 1'b0;
    ck_d   = 1'b0;
    ckc_d  = 1'b0;
    s_d    = 1'b0;
    fdr_d  = 1'b0;
    cdr_d  = 1'b0;
    unique case (state_q)
      ST_SAMPLE: begin
        s_d    = 1'b1;
        fdr_d  = 1'b1;
        cdr_d  = 1'b1;
        fp_d   = '0;
        fn_d   = '0;
        cp_d   = '0;
        cn_d   = '0;
        code_d = '0;
      end
      ST_COARSE: begin
        if (!c_ph) begin
          ckc_d = 1'b1;
          cp_d  = cp_q | c_oh;
        end else begin
          cp_d = (cp_q & ~c_oh) | (cmp_out_coarse ? c_oh : '0);
          cn_d = (cn_q & ~c_oh) | (cmp_out_coarse ? '0 : c_oh);
        end
      end
      ST_XFER: begin
        fp_d[N-1:N-K]   = cp_q;
        fn_d[N-1:N-K]   = cn_q;
        code_d[N-1:N-K] = cp_q;
      end
      ST_FINE: begin
        if (!f_ph) begin
          ck_d = 1'b1;
          // The redundant step keeps the transferred coarse value as its trial.
          if (!redund_step) fp_d = fp_q | fmask;
        end else begin
          fp_d   = (fp_q & ~fmask) | (cmp_out ? fmask : '0);
          fn_d   = (fn_q & ~fmask) | (cmp_out ? '0 : fmask);
          code_d = (code_q & ~fmask) | (cmp_out ? fmask : '0);
        end
      end
      ST_DONE: begin
        sar_d = code_q;
        eoc_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      sar_q   <= '0;
      code_q  <= '0;
      fp_q    <= '0;
      fn_q    <= '0;
      cp_q    <= '0;
      cn_q    <= '0;
      eoc_q   <= 1'b0;
      ck_q    <= 1'b0;
      ckc_q   <= 1'b0;
      s_q     <= 1'b0;
      fdr_q   <= 1'b0;
      cdr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      sar_q   <= sar_d;
      code_q  <= code_d;
      fp_q    <= fp_d;
      fn_q    <= fn_d;
      cp_q    <= cp_d;
      cn_q    <= cn_d;
      eoc_q   <= eoc_d;
      ck_q    <= ck_d;
      ckc_q   <= ckc_d;
      s_q     <= s_d;
      fdr_q   <= fdr_d;
      cdr_q   <= cdr_d;
    end
  end

  assign sar                     = sar_q;
  assign eoc                     = eoc_q;
  assign cmp_clk                 = ck_q;
  assign cmp_clk_coarse          = ckc_q;
  assign s_clk                   = s_q;
  assign fine_btm                = {fp_q, fn_q};
  assign coarse_btm              = {cp_q, cn_q};
  assign fine_switch_drain       = fdr_q;
  assign coarse_switch_drain     = cdr_q;
  assign s_clk_not               = ~s_q;
  assign fine_btm_not            = ~{fp_q, fn_q};
  assign coarse_btm_not          = ~{cp_q, cn_q};
  assign fine_switch_drain_not   = ~fdr_q;
  assign coarse_switch_drain_not = ~cdr_q;

endmodule

// File: tb/tb_sar_logic_cs_param.sv
// Self-checking bench: three controller configurations driven from shared
// control inputs, each with an event-driven comparator replaying a decision list.
module tb_sar_logic_cs_param;

  localparam int AN = 10, AK = 7, AS = 2, AR = 1, AF = AN - AK + AR;
  localparam int BN = 10, BK = 7, BS = 2, BR = 0, BF = BN - BK + BR;
  localparam int CN = 12, CK = 5, CS = 3, CR = 0, CF = CN - CK + CR;
  localparam int LAT_A = AS + 2 * AK + 1 + 2 * AF + 1;
  localparam int LAT_B = BS + 2 * BK + 1 + 2 * BF + 1;
  localparam int LAT_C = CS + 2 * CK + 1 + 2 * CF + 1;

  logic clk = 1'b0;
  logic rst, cnvst, cont;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A: defaults ----------------
  logic a_cmp = 1'b0, a_cmpc = 1'b0;
  logic [AN-1:0] a_sar;
  logic a_eoc, a_ck, a_ckc, a_s, a_fd, a_cd, a_s_n, a_fd_n, a_cd_n;
  logic [2*AN-1:0] a_fb, a_fb_n;
  logic [2*AK-1:0] a_cb, a_cb_n;

  sar_logic_cs_param #(.N(AN), .K(AK), .SAMPLE_CYCLES(AS), .REDUN(AR)) u_a (
    .clk(clk), .rst(rst), .cnvst(cnvst), .cont(cont),
    .cmp_out(a_cmp), .cmp_out_coarse(a_cmpc),
    .sar(a_sar), .eoc(a_eoc), .cmp_clk(a_ck), .cmp_clk_coarse(a_ckc), .s_clk(a_s),
    .fine_btm(a_fb), .coarse_btm(a_cb),
    .fine_switch_drain(a_fd), .coarse_switch_drain(a_cd),
    .s_clk_not(a_s_n), .fine_btm_not(a_fb_n), .coarse_btm_not(a_cb_n),
    .fine_switch_drain_not(a_fd_n), .coarse_switch_drain_not(a_cd_n)
  );

  // ---------------- instance B: no redundancy ----------------
  logic b_cmp = 1'b0, b_cmpc = 1'b0;
  logic [BN-1:0] b_sar;
  logic b_eoc, b_ck, b_ckc, b_s, b_fd, b_cd, b_s_n, b_fd_n, b_cd_n;
  logic [2*BN-1:0] b_fb, b_fb_n;
  logic [2*BK-1:0] b_cb, b_cb_n;

  sar_logic_cs_param #(.N(BN), .K(BK), .SAMPLE_CYCLES(BS), .REDUN(BR)) u_b (
    .clk(clk), .rst(rst), .cnvst(cnvst), .cont(cont),
    .cmp_out(b_cmp), .cmp_out_coarse(b_cmpc),
    .sar(b_sar), .eoc(b_eoc), .cmp_clk(b_ck), .cmp_clk_coarse(b_ckc), .s_clk(b_s),
    .fine_btm(b_fb), .coarse_btm(b_cb),
    .fine_switch_drain(b_fd), .coarse_switch_drain(b_cd),
    .s_clk_not(b_s_n), .fine_btm_not(b_fb_n), .coarse_btm_not(b_cb_n),
    .fine_switch_drain_not(b_fd_n), .coarse_switch_drain_not(b_cd_n)
  );

  // ---------------- instance C: 12-bit, 5 coarse, 3-cycle sample ----------------
  logic c_cmp = 1'b0, c_cmpc = 1'b0;
  logic [CN-1:0] c_sar;
  logic c_eoc, c_ck, c_ckc, c_s, c_fd, c_cd, c_s_n, c_fd_n, c_cd_n;
  logic [2*CN-1:0] c_fb, c_fb_n;
  logic [2*CK-1:0] c_cb, c_cb_n;

  sar_logic_cs_param #(.N(CN), .K(CK), .SAMPLE_CYCLES(CS), .REDUN(CR)) u_c (
    .clk(clk), .rst(rst), .cnvst(cnvst), .cont(cont),
    .cmp_out(c_cmp), .cmp_out_coarse(c_cmpc),
    .sar(c_sar), .eoc(c_eoc), .cmp_clk(c_ck), .cmp_clk_coarse(c_ckc), .s_clk(c_s),
    .fine_btm(c_fb), .coarse_btm(c_cb),
    .fine_switch_drain(c_fd), .coarse_switch_drain(c_cd),
    .s_clk_not(c_s_n), .fine_btm_not(c_fb_n), .coarse_btm_not(c_cb_n),
    .fine_switch_drain_not(c_fd_n), .coarse_switch_drain_not(c_cd_n)
  );

  // Decision lists: bit (width-1) is the answer to the first comparator clock.
  logic [15:0] a_cdec, a_fdec, b_cdec, b_fdec, c_cdec, c_fdec;
  int a_nc, a_nf, b_nc, b_nf, c_nc, c_nf;

  // Comparator models: present the next listed decision after each comparator clock rises.
  always @(posedge a_s) begin a_nc = 0; a_nf = 0; end
  always @(posedge a_ckc) begin a_nc++; a_cmpc = (a_nc <= AK) ? a_cdec[AK-a_nc] : 1'b0; end
  always @(posedge a_ck)  begin a_nf++; a_cmp  = (a_nf <= AF) ? a_fdec[AF-a_nf] : 1'b0; end
  always @(posedge b_s) begin b_nc = 0; b_nf = 0; end
  always @(posedge b_ckc) begin b_nc++; b_cmpc = (b_nc <= BK) ? b_cdec[BK-b_nc] : 1'b0; end
  always @(posedge b_ck)  begin b_nf++; b_cmp  = (b_nf <= BF) ? b_fdec[BF-b_nf] : 1'b0; end
  always @(posedge c_s) begin c_nc = 0; c_nf = 0; end
  always @(posedge c_ckc) begin c_nc++; c_cmpc = (c_nc <= CK) ? c_cdec[CK-c_nc] : 1'b0; end
  always @(posedge c_ck)  begin c_nf++; c_cmp  = (c_nf <= CF) ? c_fdec[CF-c_nf] : 1'b0; end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result: coarse answers form the top K bits, fine answers the rest;
  // with redundancy the first fine answer replaces bit N-K.
  function automatic logic [15:0] exp_code(input int n, input int k, input int r,
                                           input logic [15:0] cd, input logic [15:0] fd);
    logic [15:0] c;
    int fb;
    fb = n - k;
    c  = ((cd & ((16'd1 << k) - 16'd1)) << fb) | (fd & ((16'd1 << fb) - 16'd1));
    if (r != 0) c[fb] = fd[fb];
    return c;
  endfunction

  function automatic logic inv_ok();
    return (a_fb_n === ~a_fb) && (a_cb_n === ~a_cb) && (a_s_n === ~a_s) &&
           (a_fd_n === ~a_fd) && (a_cd_n === ~a_cd) &&
           (b_fb_n === ~b_fb) && (b_cb_n === ~b_cb) && (b_s_n === ~b_s) &&
           (b_fd_n === ~b_fd) && (b_cd_n === ~b_cd) &&
           (c_fb_n === ~c_fb) && (c_cb_n === ~c_cb) && (c_s_n === ~c_s) &&
           (c_fd_n === ~c_fd) && (c_cd_n === ~c_cd);
  endfunction

  function automatic logic excl_ok();
    return !((a_s && (a_ck || a_ckc)) || (b_s && (b_ck || b_ckc)) || (c_s && (c_ck || c_ckc)));
  endfunction

  task automatic run_conv(input string tag);
    int lat_a, lat_b, lat_c, ne_a, ne_b, ne_c, ns_a, ns_b, ns_c;
    logic inv_good, excl_good;
    logic [15:0] ea, eb, ec;
    lat_a = -1; lat_b = -1; lat_c = -1;
    ne_a = 0; ne_b = 0; ne_c = 0; ns_a = 0; ns_b = 0; ns_c = 0;
    inv_good = 1'b1; excl_good = 1'b1;
    ea = exp_code(AN, AK, AR, a_cdec, a_fdec);
    eb = exp_code(BN, BK, BR, b_cdec, b_fdec);
    ec = exp_code(CN, CK, CR, c_cdec, c_fdec);
    @(negedge clk); cnvst = 1'b1;
    @(posedge clk); #1; cnvst = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk); #1;
      if (a_eoc) begin ne_a++; if (lat_a < 0) lat_a = t; end
      if (b_eoc) begin ne_b++; if (lat_b < 0) lat_b = t; end
      if (c_eoc) begin ne_c++; if (lat_c < 0) lat_c = t; end
      if (a_s) ns_a++;
      if (b_s) ns_b++;
      if (c_s) ns_c++;
      if (!inv_ok()) inv_good = 1'b0;
      if (!excl_ok()) excl_good = 1'b0;
    end
    check({tag, "/lat_a"}, lat_a, LAT_A);
    check({tag, "/lat_b"}, lat_b, LAT_B);
    check({tag, "/lat_c"}, lat_c, LAT_C);
    check({tag, "/eoc_pulses"}, {ne_a[7:0], ne_b[7:0], ne_c[7:0]}, 24'h010101);
    check({tag, "/sclk_len"}, {ns_a[7:0], ns_b[7:0], ns_c[7:0]}, {8'(AS), 8'(BS), 8'(CS)});
    check({tag, "/sar_a"}, a_sar, ea);
    check({tag, "/sar_b"}, b_sar, eb);
    check({tag, "/sar_c"}, c_sar, ec);
    check({tag, "/ncmp"}, {a_nc[7:0], a_nf[7:0], c_nc[7:0], c_nf[7:0]},
          {8'(AK), 8'(AF), 8'(CK), 8'(CF)});
    check({tag, "/fbtm_a"}, a_fb, {ea[AN-1:0], ~ea[AN-1:0]});
    check({tag, "/cbtm_a"}, a_cb, {a_cdec[AK-1:0], ~a_cdec[AK-1:0]});
    check({tag, "/fbtm_c"}, c_fb, {ec[CN-1:0], ~ec[CN-1:0]});
    check({tag, "/inverses"}, inv_good, 1'b1);
    check({tag, "/clk_excl"}, excl_good, 1'b1);
  endtask

  task automatic set_all(input logic [15:0] v);
    a_cdec = v; a_fdec = v; b_cdec = v; b_fdec = v; c_cdec = v; c_fdec = v;
  endtask

  task automatic randomize_dec();
    a_cdec = 16'($urandom); a_fdec = 16'($urandom);
    b_cdec = 16'($urandom); b_fdec = 16'($urandom);
    c_cdec = 16'($urandom); c_fdec = 16'($urandom);
  endtask

  initial begin
    int a_last, c_last_t, a_cnt, c_cnt, ne_idle;
    logic a_pend;
    logic [15:0] ea, ec;

    rst = 1'b0; cnvst = 1'b0; cont = 1'b0;
    set_all(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset/sar", {a_sar, b_sar, c_sar}, '0);
    check("reset/ctrl", {a_eoc, a_ck, a_ckc, a_s, a_fd, a_cd, c_eoc, c_s}, 8'h00);
    check("reset/btm", {a_fb, a_cb, c_fb, c_cb}, '0);
    check("reset/not", {a_fb_n, a_cb_n, a_s_n, a_fd_n, a_cd_n}, {(2*AN+2*AK+3){1'b1}});
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All comparators answer 1.
    set_all(16'hFFFF);
    run_conv("ones");

    // Alternating coarse answers, fine re-decision 1 then zeros.
    set_all(16'h0000);
    a_cdec = 16'b1010101; a_fdec = 16'b1000;
    run_conv("alt");
    check("alt/sar_literal", a_sar, 10'b1010101000);

    // Coarse all ones, fine all zeros: redundancy pulls bit N-K down.
    a_cdec = 16'hFFFF; a_fdec = 16'h0000;
    b_cdec = 16'hFFFF; b_fdec = 16'h0000;
    run_conv("redun");
    check("redun/sar_a_literal", a_sar, 10'h3F0);
    check("redun/sar_b_literal", b_sar, 10'h3F8);

    // Random decision patterns.
    for (int i = 0; i < 12; i++) begin
      randomize_dec();
      run_conv($sformatf("rand%0d", i));
    end

    // Continuous mode with cnvst chattering throughout.
    randomize_dec();
    ea = exp_code(AN, AK, AR, a_cdec, a_fdec);
    ec = exp_code(CN, CK, CR, c_cdec, c_fdec);
    a_last = -1; c_last_t = -1; a_cnt = 0; c_cnt = 0; a_pend = 1'b0;
    cont = 1'b1;
    @(negedge clk); cnvst = 1'b1;
    @(posedge clk); #1; cnvst = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      @(posedge clk); #1;
      cnvst = 1'($urandom_range(0, 1));
      if (a_pend) begin
        check("cont/sclk_after_eoc", a_s, 1'b1);
        a_pend = 1'b0;
      end
      if (a_eoc) begin
        check("cont/sar_a", a_sar, ea);
        check("cont/period_a", t - a_last, (a_last < 0) ? LAT_A + 1 : LAT_A);
        a_last = t; a_cnt++; a_pend = 1'b1;
      end
      if (c_eoc) begin
        check("cont/sar_c", c_sar, ec);
        check("cont/period_c", t - c_last_t, (c_last_t < 0) ? LAT_C + 1 : LAT_C);
        c_last_t = t; c_cnt++;
      end
    end
    check("cont/count", {a_cnt[7:0], c_cnt[7:0]}, {8'(100 / LAT_A), 8'(100 / LAT_C)});
    cnvst = 1'b0; cont = 1'b0;
    repeat (70) @(posedge clk);
    #1;

    // Reset in the middle of a conversion.
    set_all(16'hFFFF);
    @(negedge clk); cnvst = 1'b1;
    @(posedge clk); #1; cnvst = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst = 1'b0; #1;
    check("midrst/sar", {a_sar, b_sar, c_sar}, '0);
    check("midrst/ctrl", {a_eoc, a_ck, a_ckc, a_s, a_fd, a_cd, c_ckc, c_s}, 8'h00);
    check("midrst/btm", {a_fb, a_cb, c_fb, c_cb}, '0);
    check("midrst/not", {a_fb_n, a_cb_n, a_s_n, a_fd_n, a_cd_n}, {(2*AN+2*AK+3){1'b1}});
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    ne_idle = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (a_eoc || b_eoc || c_eoc) ne_idle++;
    end
    check("midrst/no_eoc", ne_idle, 0);
    randomize_dec();
    run_conv("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_logic_cs_param.md
Name: sar_logic_cs_param

Overview:
- Parametrised coarse-fine SAR control logic: successor to the fixed 10-bit / 7-coarse-bit controller.
- Sequences sampling, coarse conversion (coarse comparator, coarse DAC), code transfer to the fine DAC and fine conversion. Drives bootstrap, comparator clocks and differential bottom-plate switches.
- New relative to the fixed block: N/K generic, programmable sampling length, optional redundant fine re-decision of the coarse LSB, and continuous (free-running) mode.

Parameters:
- N, 10, total resolution in bits (4..16).
- K, 7, coarse bits (1..N-1).
- SAMPLE_CYCLES, 2, clk cycles s_clk is held high (>=1).
- REDUN, 1, 1 = extra fine comparison re-deciding bit N-K; 0 = none.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cnvst  in  1  conversion start, level-sampled in IDLE.
- cont  in  1  continuous mode; sampled at DONE.
- cmp_out  in  1  fine comparator result, 1 = P side higher.
- cmp_out_coarse  in  1  coarse comparator result.
- sar  out  N  last completed code.
- eoc  out  1  end of conversion, 1-cycle pulse.
- cmp_clk  out  1  fine comparator clock.
- cmp_clk_coarse  out  1  coarse comparator clock.
- s_clk  out  1  bootstrap switch clock.
- fine_btm  out  2N  {P[N-1:0], N[N-1:0]} fine bottom-plate controls.
- coarse_btm  out  2K  {P[K-1:0], N[K-1:0]} coarse bottom-plate controls.
- fine_switch_drain  out  1  fine array drain switch.
- coarse_switch_drain  out  1  coarse array drain switch.
- s_clk_not, fine_btm_not, coarse_btm_not, fine_switch_drain_not, coarse_switch_drain_not  out  as above  bitwise complements.

Behaviour:
- Reset (rst=0, async): state IDLE. sar=0, eoc=0, cmp_clk=0, cmp_clk_coarse=0, s_clk=0, fine_btm=0, coarse_btm=0, both drains=0. The *_not outputs are all ones.
- All non-_not outputs are registered. Each _not output is the combinational inverse of its registered twin.
- FSM states: IDLE, SAMPLE, COARSE, XFER, FINE, DONE.
- IDLE:
  - cnvst=1 -> SAMPLE next cycle.
  - cnvst is ignored in every other state.
- SAMPLE:
  - s_clk=1, both drains=1, all btm=0, for SAMPLE_CYCLES cycles.
  - Then -> COARSE; s_clk and drains drop on entry.
- COARSE: bit i from K-1 down to 0, 2 cycles per bit.
  - Phase A: cmp_clk_coarse=1 and trial P[i]=1.
  - End of phase A: latch d=cmp_out_coarse. Set coarse P[i]=d, N[i]=~d.
  - Phase B: cmp_clk_coarse=0.
  - coarse_switch_drain stays 0 until next SAMPLE.
- XFER: 1 cycle.
  - fine_btm bits [N-1:N-K] of P/N are copied from coarse_btm.
  - Working code bits [N-1:N-K] = coarse decisions.
- FINE: REDUN + (N-K) bits, 2 cycles each, same A/B phasing on cmp_clk and cmp_out.
  - If REDUN=1, the first fine step re-decides bit N-K: trial = coarse value. The cmp_out result overwrites code bit N-K and fine P/N[N-K].
  - Remaining steps resolve bits N-K-1..0.
- DONE: 1 cycle.
  - sar <= working code; eoc=1.
  - cont=1 -> SAMPLE next cycle (btm cleared). Otherwise -> IDLE; btm keep final values until next SAMPLE.
- Latency, cnvst-sampled edge to eoc high: SAMPLE_CYCLES + 2K + 1 + 2(N-K+REDUN) + 1. Defaults: 26 cycles. In continuous mode, eoc repeats every 26 cycles.
- sar holds between conversions. It changes only in DONE.
- Reset mid-conversion returns every output to its reset value immediately. No eoc is produced.
- Comparator clocks are never high in the same cycle as s_clk.

Decomposition:
- Package sar_cs_pkg: state enum; function conv_latency(N, K, SAMPLE_CYCLES, REDUN).
- One sub-module, sar_bit_stepper: generic one-hot bit pointer plus A/B phase toggle with done flag, parametrised on bit count. Instantiated twice: coarse (K) and fine (N-K+REDUN).

Test Plan:
- Defaults, cmp_out=cmp_out_coarse=1, cnvst pulse: sar=10'h3FF, eoc pulse exactly 26 cycles after cnvst edge, s_clk high 2 cycles.
- Coarse alternating 1,0,1,0,1,0,1, fine=0 with REDUN=1 re-decision 1: sar=10'b1010101000.
- Redundancy correction: coarse all 1, fine 0 throughout: sar=10'h3F0 (bit 3 overridden to 0). Same stimulus with REDUN=0: sar=10'h3F8, latency 24.
- cont=1: back-to-back conversions, eoc every 26 cycles, s_clk re-asserted the cycle after each eoc. cnvst toggled mid-conversion has no effect.
- Reset at cycle 10 of a conversion: all outputs return to reset values asynchronously, no eoc. The next cnvst gives a full-latency conversion.
- N=12, K=5, SAMPLE_CYCLES=3, REDUN=0: all-1 comparators give sar=12'hFFF at latency 3+10+1+14+1=29, fine_btm_not == ~fine_btm throughout.
